// File: rtl/comparador_serial.sv
`default_nettype none
// ============================================================================
// Module   : comparador_serial
// Brief    : Serial cascadable magnitude comparator. It compares one slice per
//            clock, starting at the MSB slice, and stops at the first unequal
//            slice. Define SIGNED_CMP_EN for a two's-complement compare.
// Revision : 1.0 - initial release
// ============================================================================
module comparador_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             G_IN,
  input  logic             L_IN,
  input  logic             E_IN,
  output logic             busy,
  output logic             done,
  output logic             G,
  output logic             L,
  output logic             E
);

  localparam int c_N  = WIDTH / SLICE;
  localparam int c_IW = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(c_N - 1);
  localparam logic [c_IW-1:0] c_ONE  = c_IW'(1);

  generate
    if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_param_check
      $error("comparador_serial: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CMP  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_gin;
  logic             r_lin;
  logic             r_ein;
  logic [c_IW-1:0]  r_idx;
  logic             r_done;
  logic             r_g;
  logic             r_l;
  logic             r_e;

  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic             w_ld;
  logic             w_fin;
  logic             w_dec;
  logic             w_g_nxt;
  logic             w_l_nxt;
  logic             w_e_nxt;

  // The slice under test. In signed mode, flipping the sign bit of the MSB
  // slice turns a two's-complement order into an unsigned order.
  always_comb begin
    w_sa = r_a[int'(r_idx)*SLICE +: SLICE];
    w_sb = r_b[int'(r_idx)*SLICE +: SLICE];
`ifdef SIGNED_CMP_EN
    if (r_idx == c_LAST) begin
      w_sa[SLICE-1] = ~w_sa[SLICE-1];
      w_sb[SLICE-1] = ~w_sb[SLICE-1];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_fin       = 1'b0;
    w_dec       = 1'b0;
    w_g_nxt     = r_gin;
    w_l_nxt     = r_lin;
    w_e_nxt     = r_ein;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_ld        = 1'b1;
          w_state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        if (w_sa != w_sb) begin
          w_g_nxt     = (w_sa > w_sb);
          w_l_nxt     = (w_sa < w_sb);
          w_e_nxt     = 1'b0;
          w_fin       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_idx == '0) begin
          w_fin       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_gin  <= 1'b0;
      r_lin  <= 1'b0;
      r_ein  <= 1'b0;
      r_idx  <= '0;
      r_done <= 1'b0;
      r_g    <= 1'b0;
      r_l    <= 1'b0;
      r_e    <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_ld) begin
        r_a   <= A;
        r_b   <= B;
        r_gin <= G_IN;
        r_lin <= L_IN;
        r_ein <= E_IN;
        r_idx <= c_LAST;
      end else if (w_dec) begin
        r_idx <= r_idx - c_ONE;
      end
      // Results are held across later starts until the next completion.
      if (w_fin) begin
        r_g <= w_g_nxt;
        r_l <= w_l_nxt;
        r_e <= w_e_nxt;
      end
    end
  end

  assign busy = (r_state == S_CMP);
  assign done = r_done;
  assign G    = r_g;
  assign L    = r_l;
  assign E    = r_e;

endmodule
`default_nettype wire

// File: tb/tb_comparador_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_comparador_serial
// Brief    : Directed self-checking bench for comparador_serial (WIDTH=16, SLICE=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_comparador_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        G_IN;
  logic        L_IN;
  logic        E_IN;
  logic        busy;
  logic        done;
  logic        G;
  logic        L;
  logic        E;

  int n_cmp = 0;
  int n_err = 0;

  comparador_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .G_IN  (G_IN),
    .L_IN  (L_IN),
    .E_IN  (E_IN),
    .busy  (busy),
    .done  (done),
    .G     (G),
    .L     (L),
    .E     (E)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation; inputs are scrambled after the start edge so that
  // only the latched copies can produce the expected result.
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic gi, input logic li, input logic ei,
                     input int exp_lat, input logic eg, input logic el, input logic ee);
    int lat;
    A = a; B = b; G_IN = gi; L_IN = li; E_IN = ei; start = 1'b1;
    tick();
    start = 1'b0;
    A = ~a; B = ~b; G_IN = ~gi; L_IN = ~li; E_IN = ~ei;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_gle"}, {29'd0, G, L, E}, {29'd0, eg, el, ee});
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    tick();
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; G_IN = 1'b0; L_IN = 1'b0; E_IN = 1'b0;
    #2;
    chk("reset", {27'd0, busy, done, G, L, E}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run("eq_cascade_e", 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b1);
    run("lsb_greater",  16'h1235, 16'h1234, 1'b0, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0);
    run("msb_greater",  16'h2000, 16'h1FFF, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
`ifdef SIGNED_CMP_EN
    run("sign_msb",     16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0);
`else
    run("sign_msb",     16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
`endif
    run("cascade_g",    16'h5555, 16'h5555, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    run("cascade_l",    16'h5555, 16'h5555, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0);
    run("cascade_raw",  16'hC3C3, 16'hC3C3, 1'b1, 1'b1, 1'b1, 4, 1'b1, 1'b1, 1'b1);
    run("slice2_less",  16'h0300, 16'h0400, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0);

    // start while busy is ignored; start in the done cycle is accepted
    A = 16'h0001; B = 16'h0001; G_IN = 1'b0; L_IN = 1'b0; E_IN = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 16'h0005; B = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("busy_start_edge3", {30'd0, busy, done}, 32'b10);
    tick();
    chk("busy_start_done", {31'd0, done}, 32'd1);
    chk("busy_start_gle", {29'd0, G, L, E}, 32'b001);
    A = 16'h0300; B = 16'h0400; G_IN = 1'b1; L_IN = 1'b0; E_IN = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_cycle_accept", {30'd0, busy, done}, 32'b10);
    chk("result_held", {29'd0, G, L, E}, 32'b001);
    tick();
    chk("done_cycle_k1", {31'd0, done}, 32'd0);
    tick();
    chk("done_cycle_k2", {30'd0, done, L}, 32'b11);

    // asynchronous reset in the middle of an operation
    tick();
    A = 16'hAAAA; B = 16'hAAAA; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset", {27'd0, busy, done, G, L, E}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("mid_reset_no_done", {31'd0, saw_done}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    run("post_reset", 16'h0F00, 16'h0E00, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
